pic_timer0: RTL
===============

Name: pic_timer0

Overview:
- Memory-mapped Timer0 / interrupt-control peripheral that sits on the PIC core's data bus as a bus responder.
- Decodes core addresses and returns read data; accepts write strobes.
- Implements the TMR0, OPTION_REG and INTCON special function registers with an 8-bit prescaler and INT-pin edge capture.
- Drives the core's Interrupt input.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the T0CKI and INT pin synchronisers (min 2).
- INHIBIT_CYCLES, 2, instruction cycles (Sync pulses) during which TMR0 does not increment after a TMR0 write.

Ports:
- Clk  in  1  system clock (4 clocks per instruction cycle).
- Reset  in  1  asynchronous, active-high reset.
- Sync  in  1  one-clock pulse per instruction cycle from the core (Fosc/4 tick).
- Address  in  9  core bus address {bank, offset}.
- Data_In  in  8  core write data (core's Data_Out).
- Latch  in  1  core write strobe; write occurs on the Clk edge where Latch=1.
- GIE  in  1  core's global interrupt enable; reflected in INTCON[7] reads.
- T0CKI  in  1  asynchronous external Timer0 clock pin.
- INT  in  1  asynchronous external interrupt pin.
- Data_Out  out  8  registered read data for the addressed register.
- Select  out  1  registered; 1 when Address hits a register in this block (top level ORs/muxes responders).
- Interrupt  out  1  (T0IE & T0IF) | (INTE & INTF), combinational from registers.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset asynchronous and active-high; all state below is initialised while Reset=1.
- Address decode uses the 9-bit address:
  - TMR0 = 0x001, 0x101.
  - OPTION_REG = 0x081, 0x181.
  - INTCON = 0x00B, 0x08B, 0x10B, 0x18B.
  - All other addresses: Select=0, Data_Out=0x00 on the next clock.
- Read path:
  - Data_Out and Select update every clock from the current Address (one-clock latency).
  - The core samples in its ClockCycle 1, so the address must be stable by cycle 0.
  - INTCON read = {GIE, PEIE, T0IE, INTE, RBIE, T0IF, INTF, RBIF}.
- Write path:
  - On the Clk edge with Latch=1 and a decode hit, the register takes Data_In.
  - INTCON[7] is not stored (the core owns GIE).
  - PEIE, RBIE and RBIF are storage only.
- Reset values:
  - TMR0=0x00, OPTION_REG=0xFF, INTCON stored bits=0, prescaler=0, inhibit counter=0, synchronisers=0.
  - Data_Out=0x00, Select=0, Interrupt=0.
- OPTION_REG bit fields: [7] nRBPU (storage), [6] INTEDG, [5] T0CS, [4] T0SE, [3] PSA, [2:0] PS.
- Tick source:
  - T0CS=0: tick = Sync.
  - T0CS=1: tick = synchronised T0CKI edge, rising if T0SE=0, falling if T0SE=1. One tick per edge, one clock wide.
- Prescaler (8-bit):
  - PSA=1: every tick increments TMR0; prescaler is held at 0.
  - PSA=0: every tick increments the prescaler. TMR0 increments on ticks where (prescaler & M)==M, M=(2<<PS)-1, giving ratio 2^(PS+1): 1:2 at PS=0 up to 1:256 at PS=7.
- TMR0 write:
  - Loads TMR0, clears the prescaler, and loads the inhibit counter with INHIBIT_CYCLES.
  - Inhibit counter decrements on each Sync; TMR0 increments are suppressed while it is nonzero. Prescaler keeps counting.
- Any OPTION_REG write clears the prescaler.
- Overflow:
  - A TMR0 increment from 0xFF to 0x00 sets T0IF in the same clock.
  - Wraps with no saturation.
- INT pin: synchronised edge selected by INTEDG (1=rising, 0=falling) sets INTF.
- Simultaneous events:
  - TMR0 write and increment on the same clock: the write wins.
  - Hardware set of T0IF/INTF and an INTCON write clearing it on the same clock: the set wins (flag reads 1).
  - INTCON write setting a flag: flag set (software interrupt).
- Interrupt output:
  - Does not depend on GIE; the core gates it.
  - Stays high until software clears the flag or the enable.
- Reset mid-count: all counters and flags return to reset values immediately; no pending tick survives.

Test Plan:
- Reset, then read 0x081, 0x00B, 0x001 -> Data_Out 0xFF, 0x00 (GIE=0), 0x00 one clock after each address; Select=1. Read 0x020 -> Select=0, Data_Out=0x00.
- Write OPTION_REG=0x08 (Fosc/4, no prescale), TMR0=0xFE -> no increment for 2 Sync pulses, then 0xFF, then 0x00 with T0IF=1. With T0IE set, Interrupt=1.
- OPTION_REG=0x02 (PSA=0, 1:8), TMR0=0x00 -> after inhibit, TMR0 increments once per 8 Sync pulses; 80 Sync pulses give TMR0=0x0A (±1 for inhibit alignment, checked exactly by model).
- T0CS=1, T0SE=1, PSA=1; toggle T0CKI 5 full periods -> TMR0=5, counted on falling edges only, each ≥SYNC_STAGES clocks after the edge.
- INTEDG=0, INTE=1; INT falling edge -> INTF=1, Interrupt=1. Write INTCON=0x10 -> INTF=0, Interrupt=0. Repeat with the edge arriving on the clearing write's clock -> INTF remains 1.
- Assert Reset mid-count with TMR0=0x80 and prescaler nonzero -> TMR0=0x00, OPTION_REG=0xFF, Interrupt=0 immediately (asynchronous).

Source files
------------

// File: rtl/pic_timer0.sv
// Timer0 / interrupt-control responder for the PIC data bus: TMR0, OPTION_REG and INTCON
// with an 8-bit prescaler, T0CKI/INT pin synchronisers and the core Interrupt request.
module pic_timer0 #(
  parameter int SYNC_STAGES    = 2,
  parameter int INHIBIT_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Sync,
  input  logic [8:0] Address,
  input  logic [7:0] Data_In,
  input  logic       Latch,
  input  logic       GIE,
  input  logic       T0CKI,
  input  logic       INT,
  output logic [7:0] Data_Out,
  output logic       Select,
  output logic       Interrupt
);

  localparam int SS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int INH_W = (INHIBIT_CYCLES < 2) ? 1 : $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES);

  // Low PS+1 bits set: TMR0 advances when all of them are set in the prescaler.
  function automatic logic [7:0] presc_mask(input logic [2:0] ps);
    logic [8:0] span;
    span = 9'd2 << ps;
    return span[7:0] - 8'd1;
  endfunction

  logic [7:0]       tmr0;
  logic [7:0]       option_reg;
  logic [6:0]       intcon_q;
  logic [7:0]       prescaler;
  logic [INH_W-1:0] inhibit_cnt;

  logic [SS-1:0]    t0cki_sync;
  logic [SS-1:0]    int_sync;
  logic             t0cki_prev;
  logic             int_prev;

  logic             hit_tmr0;
  logic             hit_option;
  logic             hit_intcon;
  logic             hit_any;
  logic             wr_tmr0;
  logic             wr_option;
  logic             wr_intcon;

  logic             opt_intedg;
  logic             opt_t0cs;
  logic             opt_t0se;
  logic             opt_psa;
  logic [2:0]       opt_ps;

  logic             t0_rise;
  logic             t0_fall;
  logic             int_rise;
  logic             int_fall;
  logic             tick;
  logic             presc_hit;
  logic             tmr0_inc;
  logic             t0if_set;
  logic             intf_set;
  logic [6:0]       intcon_nxt;
  logic [7:0]       rd_data;

  assign hit_tmr0   = (Address[6:0] == 7'h01) && !Address[7];
  assign hit_option = (Address[6:0] == 7'h01) &&  Address[7];
  assign hit_intcon = (Address[6:0] == 7'h0B);
  assign hit_any    = hit_tmr0 | hit_option | hit_intcon;

  assign wr_tmr0    = Latch & hit_tmr0;
  assign wr_option  = Latch & hit_option;
  assign wr_intcon  = Latch & hit_intcon;

  assign opt_intedg = option_reg[6];
  assign opt_t0cs   = option_reg[5];
  assign opt_t0se   = option_reg[4];
  assign opt_psa    = option_reg[3];
  assign opt_ps     = option_reg[2:0];

  // Pin synchronisers; the extra prev flop turns each settled level change into a one-clock pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      t0cki_sync <= '0;
      int_sync   <= '0;
      t0cki_prev <= 1'b0;
      int_prev   <= 1'b0;
    end else begin
      t0cki_sync <= {t0cki_sync[SS-2:0], T0CKI};
      int_sync   <= {int_sync[SS-2:0], INT};
      t0cki_prev <= t0cki_sync[SS-1];
      int_prev   <= int_sync[SS-1];
    end
  end

  assign t0_rise  =  t0cki_sync[SS-1] & ~t0cki_prev;
  assign t0_fall  = ~t0cki_sync[SS-1] &  t0cki_prev;
  assign int_rise =  int_sync[SS-1]   & ~int_prev;
  assign int_fall = ~int_sync[SS-1]   &  int_prev;

  assign tick      = opt_t0cs ? (opt_t0se ? t0_fall : t0_rise) : Sync;
  assign presc_hit = opt_psa | ((prescaler & presc_mask(opt_ps)) == presc_mask(opt_ps));
  assign tmr0_inc  = tick & presc_hit & (inhibit_cnt == '0);

  // A TMR0 write on the same edge discards the increment, and with it any overflow.
  assign t0if_set  = tmr0_inc & (tmr0 == 8'hFF) & ~wr_tmr0;
  assign intf_set  = opt_intedg ? int_rise : int_fall;

  // Hardware flag sets override a software clear arriving on the same edge.
  always_comb begin
    intcon_nxt = intcon_q;
    if (wr_intcon) intcon_nxt = Data_In[6:0];
    if (t0if_set)  intcon_nxt[2] = 1'b1;
    if (intf_set)  intcon_nxt[1] = 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tmr0        <= 8'h00;
      option_reg  <= 8'hFF;
      intcon_q    <= '0;
      prescaler   <= 8'h00;
      inhibit_cnt <= '0;
    end else begin
      if (wr_tmr0)
        tmr0 <= Data_In;
      else if (tmr0_inc)
        tmr0 <= tmr0 + 8'd1;

      if (wr_tmr0 | wr_option | opt_psa)
        prescaler <= 8'h00;
      else if (tick)
        prescaler <= prescaler + 8'd1;

      if (wr_tmr0)
        inhibit_cnt <= INH_LOAD;
      else if (Sync && (inhibit_cnt != '0))
        inhibit_cnt <= inhibit_cnt - INH_W'(1);

      if (wr_option)
        option_reg <= Data_In;

      intcon_q <= intcon_nxt;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (hit_tmr0)
      rd_data = tmr0;
    else if (hit_option)
      rd_data = option_reg;
    else if (hit_intcon)
      rd_data = {GIE, intcon_q};
  end

  // Bus response: registered one clock after the address.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Data_Out <= 8'h00;
      Select   <= 1'b0;
    end else begin
      Data_Out <= rd_data;
      Select   <= hit_any;
    end
  end

  assign Interrupt = (intcon_q[5] & intcon_q[2]) | (intcon_q[4] & intcon_q[1]);

endmodule
